// File: rtl/md_unit_ctrl_pkg.sv
// Shared types for the multiply/divide sequencer.
//   md_op_e    : command codes carried on op[2:0]
//   md_state_e : sequencer states
//   md_compute : 64-bit {hi, lo} result of a mult/multu/div/divu command
package md_unit_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int CNT_W = 4;

  // Result is {hi, lo}. Divide by zero and the signed overflow case are
  // resolved here so the pipeline never sees an undefined value, and the
  // divisor fed to the operators is never zero.
  function automatic logic [63:0] md_compute(input md_op_e op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic        [31:0] bsafe;
    logic        [31:0] q;
    logic        [31:0] r;
    sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    uprod = {32'd0, a} * {32'd0, b};
    bsafe = (b == 32'd0) ? 32'd1 : b;
    q     = 32'd0;
    r     = 32'd0;
    case (op)
      MD_MULT:  md_compute = sprod;
      MD_MULTU: md_compute = uprod;
      MD_DIV: begin
        if (b == 32'd0) begin
          md_compute = {a, 32'hffff_ffff};
        end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
          md_compute = {32'd0, 32'h8000_0000};
        end else begin
          // SV signed / and % truncate toward zero; remainder follows a.
          q = $signed(a) / $signed(bsafe);
          r = $signed(a) % $signed(bsafe);
          md_compute = {r, q};
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          md_compute = {a, 32'hffff_ffff};
        end else begin
          q = a / bsafe;
          r = a % bsafe;
          md_compute = {r, q};
        end
      end
      default: md_compute = 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// E-stage <-> MD unit bundle.
//   start/op/A/B : command from E (master drives)
//   busy/HI/LO   : registered status and committed HI/LO (slave drives)
interface md_unit_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, op, A, B, input  busy, HI, LO);
  modport slave  (input  start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide sequencer beside the E-stage ALU.
// The result is computed at the accepting edge and parked in a pending
// register; HI/LO are only updated when the countdown expires, so mfhi/mflo
// always see the committed value. busy is high for exactly N cycles.
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-high
//   md    : command in (start/op/A/B), status/result out (busy/HI/LO)
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  md_unit_ctrl_if.slave md
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [63:0]        pend_q, pend_d;
  md_op_e             op;

  assign op = md_op_e'(md.op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    case (state_q)
      MD_IDLE: begin
        if (md.start) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              pend_d  = md_compute(op, md.A, md.B);
              cnt_d   = CNT_W'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = MD_RUN;
            end
            MD_DIV, MD_DIVU: begin
              pend_d  = md_compute(op, md.A, md.B);
              cnt_d   = CNT_W'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = MD_RUN;
            end
            MD_MTHI: hi_d = md.A;
            MD_MTLO: lo_d = md.A;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        // Commands arriving here are dropped; the hazard unit stalls them.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          busy_d  = 1'b0;
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign md.busy = busy_q;
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl with a result scoreboard.
module tb_md_unit_ctrl;

  logic clk = 1'b0;
  logic reset;

  md_unit_ctrl_if md();

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .md   (md.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one long op, count busy cycles, verify HI/LO hold while busy,
  // optionally fire an illegal start at busy cycle inj, then check commit.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int n, input int inj, input string tag);
    exp_t e;
    int   cyc;
    logic hold_ok;
    e.hi = exp_hi; e.lo = exp_lo; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    md.start = 1'b1; md.op = op; md.A = a; md.B = b;
    @(negedge clk);
    md.start = 1'b0; md.op = 3'd0;
    cyc = 0;
    hold_ok = 1'b1;
    while (md.busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (md.HI !== model_hi || md.LO !== model_lo) hold_ok = 1'b0;
      if (cyc == inj) begin
        md.start = 1'b1; md.op = 3'd1; md.A = 32'd7; md.B = 32'd9;
      end else begin
        md.start = 1'b0; md.op = 3'd0;
      end
      @(negedge clk);
    end
    md.start = 1'b0; md.op = 3'd0;
    chk(32'(cyc), 32'(n), {tag, " busy_cycles"});
    chk({31'd0, hold_ok}, 32'd1, {tag, " hold"});
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s: scoreboard empty got 0 expected 1", tag);
    end else begin
      e = sb.pop_front();
      chk(md.HI, e.hi, {e.tag, " HI"});
      chk(md.LO, e.lo, {e.tag, " LO"});
      model_hi = e.hi;
      model_lo = e.lo;
    end
  endtask

  initial begin
    reset = 1'b1;
    md.start = 1'b0; md.op = 3'd0; md.A = '0; md.B = '0;
    repeat (2) @(negedge clk);
    chk({31'd0, md.busy}, 32'd0, "reset busy");
    chk(md.HI, 32'd0, "reset HI");
    chk(md.LO, 32'd0, "reset LO");
    reset = 1'b0;

    run_op(3'd1, 32'hffff_ffff, 32'd2, 32'hffff_ffff, 32'hffff_fffe, 5, 0, "mult -1*2");
    run_op(3'd2, 32'hffff_ffff, 32'd2, 32'h0000_0001, 32'hffff_fffe, 5, 0, "multu");
    run_op(3'd3, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, 10, 0, "div -7/2");
    run_op(3'd3, 32'd7, 32'hffff_fffe, 32'd1, 32'hffff_fffd, 10, 0, "div 7/-2");
    run_op(3'd4, 32'd100, 32'd0, 32'd100, 32'hffff_ffff, 10, 0, "divu 100/0");
    run_op(3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10, 0, "divu 100/7");
    run_op(3'd3, 32'hffff_fffb, 32'd0, 32'hffff_fffb, 32'hffff_ffff, 10, 0, "div -5/0");
    run_op(3'd3, 32'h8000_0000, 32'hffff_ffff, 32'd0, 32'h8000_0000, 10, 0, "div ovf");

    // mthi then mtlo back to back
    @(negedge clk);
    md.start = 1'b1; md.op = 3'd5; md.A = 32'h1234_5678;
    @(negedge clk);
    chk(md.HI, 32'h1234_5678, "mthi HI");
    chk({31'd0, md.busy}, 32'd0, "mthi busy");
    md.op = 3'd6; md.A = 32'h9abc_def0;
    @(negedge clk);
    md.start = 1'b0; md.op = 3'd0;
    chk(md.LO, 32'h9abc_def0, "mtlo LO");
    chk(md.HI, 32'h1234_5678, "mtlo HI kept");
    chk({31'd0, md.busy}, 32'd0, "mtlo busy");
    model_hi = 32'h1234_5678;
    model_lo = 32'h9abc_def0;

    // op 0 and op 7 with start do nothing
    md.start = 1'b1; md.op = 3'd0; md.A = 32'hdead_beef;
    @(negedge clk);
    md.op = 3'd7;
    @(negedge clk);
    md.start = 1'b0; md.op = 3'd0;
    chk({31'd0, md.busy}, 32'd0, "nop busy");
    chk(md.HI, model_hi, "nop HI");
    chk(md.LO, model_lo, "nop LO");

    // mult start at busy cycle 3 of a div is ignored
    run_op(3'd3, 32'hffff_ff9c, 32'd7, 32'hffff_fffe, 32'hffff_fff2, 10, 3, "div ignore");
    @(negedge clk);
    chk({31'd0, md.busy}, 32'd0, "ignored mult busy");

    // async reset at counter=4 of a div
    sb.push_back('{hi: 32'd0, lo: 32'd0, tag: "aborted"});
    md.start = 1'b1; md.op = 3'd3; md.A = 32'd50; md.B = 32'd3;
    @(negedge clk);
    md.start = 1'b0; md.op = 3'd0;
    repeat (6) @(negedge clk);
    chk({31'd0, md.busy}, 32'd1, "pre-reset busy");
    #2 reset = 1'b1;
    #1;
    chk({31'd0, md.busy}, 32'd0, "async reset busy");
    chk(md.HI, 32'd0, "async reset HI");
    chk(md.LO, 32'd0, "async reset LO");
    void'(sb.pop_back());
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    reset = 1'b0;

    run_op(3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5, 0, "mult after reset");
    chk(32'(sb.size()), 32'd0, "scoreboard drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
